bus_interconnect: RTL

Parametrised N-master × M-slave bus interconnect that replaces the fixed per-bus interconnects of the SoC. It does the following:
- decodes each master request against per-slave base/mask windows;
- arbitrates each slave round-robin among masters;
- answers unmapped addresses and hung slaves with an error completion instead of stalling the core.

It sits between the `rv_core` bus masters and the memory, ROM and GPIO slave wrappers.

---
 rtl/bus_interconnect.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_interconnect.sv
// bus_interconnect: N-master x M-slave bus fabric with base/mask decode,
// per-slave round-robin arbitration and error completion for misses/timeouts.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   m_bstart/m_addr/m_ttype/     per-master request (held until m_bdone)
//   m_tsize/m_wdata
//   m_rdata/m_bdone/m_berr       per-master completion
//   s_ss/s_bstart/s_addr/...     per-slave forwarded request
//   s_rdata/s_bdone              per-slave response
module bus_interconnect #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_MASTERS-1:0]         m_bstart,
    input  logic [N_MASTERS*ADDR_W-1:0]  m_addr,
    input  logic [N_MASTERS-1:0]         m_ttype,
    input  logic [N_MASTERS*2-1:0]       m_tsize,
    input  logic [N_MASTERS*DATA_W-1:0]  m_wdata,
    output logic [N_MASTERS*DATA_W-1:0]  m_rdata,
    output logic [N_MASTERS-1:0]         m_bdone,
    output logic [N_MASTERS-1:0]         m_berr,
    output logic [N_SLAVES-1:0]          s_ss,
    output logic [N_SLAVES-1:0]          s_bstart,
    output logic [N_SLAVES*ADDR_W-1:0]   s_addr,
    output logic [N_SLAVES-1:0]          s_ttype,
    output logic [N_SLAVES*2-1:0]        s_tsize,
    output logic [N_SLAVES*DATA_W-1:0]   s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]          s_bdone
);

    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, PEND, ACTIVE, ERR} mst_e;

    mst_e              st_q   [N_MASTERS];
    logic [SW-1:0]     tgt_q  [N_MASTERS];
    logic [N_SLAVES-1:0] busy_q;
    logic [MW-1:0]     own_q  [N_SLAVES];
    logic [MW-1:0]     rr_q   [N_SLAVES];
    logic [CW-1:0]     cnt_q  [N_SLAVES];

    logic [N_MASTERS-1:0] hit;
    logic [SW-1:0]        hit_idx [N_MASTERS];
    logic [N_SLAVES-1:0]  gnt;
    logic [MW-1:0]        gnt_idx [N_SLAVES];
    logic [N_MASTERS-1:0] m_gnt;
    logic [N_SLAVES-1:0]  s_ok;
    logic [N_SLAVES-1:0]  s_to;

    // Decode: scan downward so the lowest matching window wins.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            hit[m]     = 1'b0;
            hit_idx[m] = '0;
            for (int j = N_SLAVES - 1; j >= 0; j--) begin
                if ((m_addr[m*ADDR_W +: ADDR_W] & SLAVE_MASK[j*ADDR_W +: ADDR_W])
                    == SLAVE_BASE[j*ADDR_W +: ADDR_W]) begin
                    hit[m]     = 1'b1;
                    hit_idx[m] = SW'(j);
                end
            end
        end
    end

    // Round-robin: first pass from rr upward, second pass wraps below rr.
    always_comb begin
        m_gnt = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            gnt[j]     = 1'b0;
            gnt_idx[j] = '0;
            if (!busy_q[j]) begin
                for (int m = 0; m < N_MASTERS; m++) begin
                    if (!gnt[j] && m >= int'(rr_q[j]) && st_q[m] == PEND
                        && tgt_q[m] == SW'(j)) begin
                        gnt[j]     = 1'b1;
                        gnt_idx[j] = MW'(m);
                    end
                end
                for (int m = 0; m < N_MASTERS; m++) begin
                    if (!gnt[j] && m < int'(rr_q[j]) && st_q[m] == PEND
                        && tgt_q[m] == SW'(j)) begin
                        gnt[j]     = 1'b1;
                        gnt_idx[j] = MW'(m);
                    end
                end
            end
            for (int m = 0; m < N_MASTERS; m++) begin
                if (gnt[j] && gnt_idx[j] == MW'(m)) m_gnt[m] = 1'b1;
            end
        end
    end

    // s_bdone has priority over a timeout landing in the same cycle.
    always_comb begin
        for (int j = 0; j < N_SLAVES; j++) begin
            s_ok[j] = busy_q[j] & s_bdone[j];
            s_to[j] = busy_q[j] & ~s_bdone[j] & (TIMEOUT_CYCLES != 0)
                      & (cnt_q[j] == CW'(TIMEOUT_CYCLES));
        end
    end

    always_comb begin
        m_bdone = '0;
        m_berr  = '0;
        m_rdata = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (st_q[m] == ERR) begin
                m_bdone[m] = 1'b1;
                m_berr[m]  = 1'b1;
            end
            for (int j = 0; j < N_SLAVES; j++) begin
                if (own_q[j] == MW'(m)) begin
                    if (s_ok[j]) begin
                        m_bdone[m] = 1'b1;
                        m_rdata[m*DATA_W +: DATA_W] = s_rdata[j*DATA_W +: DATA_W];
                    end else if (s_to[j]) begin
                        m_bdone[m] = 1'b1;
                        m_berr[m]  = 1'b1;
                    end
                end
            end
        end
    end

    // The request is forwarded already in the grant cycle so the slave
    // sees address and strobe together.
    always_comb begin
        logic [MW-1:0] cur;
        logic          act;
        s_ss     = '0;
        s_bstart = '0;
        s_addr   = '0;
        s_ttype  = '0;
        s_tsize  = '0;
        s_wdata  = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            act         = busy_q[j] | gnt[j];
            cur         = gnt[j] ? gnt_idx[j] : own_q[j];
            s_ss[j]     = act;
            s_bstart[j] = gnt[j];
            for (int m = 0; m < N_MASTERS; m++) begin
                if (act && cur == MW'(m)) begin
                    s_addr[j*ADDR_W +: ADDR_W]  = m_addr[m*ADDR_W +: ADDR_W];
                    s_ttype[j]                  = m_ttype[m];
                    s_tsize[j*2 +: 2]           = m_tsize[m*2 +: 2];
                    s_wdata[j*DATA_W +: DATA_W] = m_wdata[m*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < N_MASTERS; m++) begin
                st_q[m]  <= IDLE;
                tgt_q[m] <= '0;
            end
            busy_q <= '0;
            for (int j = 0; j < N_SLAVES; j++) begin
                own_q[j] <= '0;
                rr_q[j]  <= '0;
                cnt_q[j] <= '0;
            end
        end else begin
            for (int m = 0; m < N_MASTERS; m++) begin
                unique case (st_q[m])
                    IDLE: begin
                        if (m_bstart[m]) begin
                            if (hit[m]) begin
                                st_q[m]  <= PEND;
                                tgt_q[m] <= hit_idx[m];
                            end else begin
                                st_q[m] <= ERR;
                            end
                        end
                    end
                    PEND:    if (m_gnt[m]) st_q[m] <= ACTIVE;
                    ACTIVE:  if (m_bdone[m]) st_q[m] <= IDLE;
                    ERR:     st_q[m] <= IDLE;
                    default: st_q[m] <= IDLE;
                endcase
            end
            for (int j = 0; j < N_SLAVES; j++) begin
                if (gnt[j]) begin
                    busy_q[j] <= 1'b1;
                    own_q[j]  <= gnt_idx[j];
                    cnt_q[j]  <= CW'(1);
                    if (gnt_idx[j] == MW'(N_MASTERS - 1)) rr_q[j] <= '0;
                    else rr_q[j] <= gnt_idx[j] + MW'(1);
                end else if (s_ok[j] || s_to[j]) begin
                    busy_q[j] <= 1'b0;
                    cnt_q[j]  <= '0;
                end else if (busy_q[j]) begin
                    cnt_q[j] <= cnt_q[j] + CW'(1);
                end
            end
        end
    end

endmodule
